// File: rtl/gelato_ram_pkg.sv
// ---------------------------------------------------------------------------
// gelato_ram_pkg
// Shared types and helpers for the instruction RAM responder.
//   - ram_state_e : responder FSM states (IDLE, WAIT, BURST)
//   - BYTE_OFFSET_BITS / LINE_OFFSET_BITS / BEAT_BITS : address split for the
//     default build (32-bit words, 8-word lines)
//   - line_base() : clears the in-line offset bits of a byte address
// ---------------------------------------------------------------------------
package gelato_ram_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } ram_state_e;

   // Default geometry: 32-bit words, 8 words per line
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_LINE_WORDS = 8;
   localparam int BYTE_OFFSET_BITS   = $clog2(DEFAULT_DATA_WIDTH / 8);
   localparam int BEAT_BITS          = $clog2(DEFAULT_LINE_WORDS);
   localparam int LINE_OFFSET_BITS   = BYTE_OFFSET_BITS + BEAT_BITS;

   // Byte address of the start of the line containing addr.
   // Addresses are carried at 64 bits so one helper serves any ADDR_WIDTH.
   function automatic logic [63:0] line_base(input logic [63:0] addr,
                                             input int          line_off_bits);
      logic [63:0] mask;
      mask = ~64'd0 << line_off_bits;
      return addr & mask;
   endfunction

endpackage

// File: rtl/gelato_ram_array.sv
// ---------------------------------------------------------------------------
// gelato_ram_array
// Program storage for the instruction RAM responder. Writes are synchronous
// (preload port), reads are asynchronous so the current beat's word is
// available in the same cycle its index is presented.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe (already qualified by the global enable)
//   wr_addr  in   word index to write
//   wr_data  in   word to write
//   rd_addr  in   word index to read
//   rd_data  out  word at rd_addr (combinational)
// ---------------------------------------------------------------------------
module gelato_ram_array
   import gelato_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_BITS  = 14
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_BITS-1:0]  wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_BITS-1:0]  rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   // Contents are deliberately not reset: the host preloads the program.
   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];

   // Preload write port: one word per enabled edge
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Asynchronous read path
   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/gelato_inst_ram_responder.sv
// ---------------------------------------------------------------------------
// gelato_inst_ram_responder
// Memory-side target for L1 instruction line fills. Accepts one line request
// at a time, waits LATENCY cycles, then returns LINE_WORDS words as a
// valid/ready burst. Requests whose line does not lie in storage return a
// single error beat instead. A host preload port fills storage before launch.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low freezes every register
//   req_valid/ready request handshake; req_addr is any byte inside the line
//   resp_valid/ready response beat handshake
//   resp_data       instruction word (0 on error beats and when idle)
//   resp_last       final beat of the response
//   resp_error      request address out of range
//   load_en/addr/data  preload write port (word indexed)
// ---------------------------------------------------------------------------
module gelato_inst_ram_responder
   import gelato_ram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int LINE_WORDS     = 8,
   parameter int MEM_WORDS_LOG2 = 14,
   parameter int LATENCY        = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [DATA_WIDTH-1:0]     resp_data,
   output logic                      resp_last,
   output logic                      resp_error,
   input  logic                      load_en,
   input  logic [MEM_WORDS_LOG2-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0]     load_data
);

   localparam int BYTE_OFF_BITS = $clog2(DATA_WIDTH / 8);
   localparam int BEAT_W        = $clog2(LINE_WORDS);
   localparam int LINE_OFF_BITS = BYTE_OFF_BITS + BEAT_W;
   localparam int CNT_W         = (LATENCY < 2) ? 1 : $clog2(LATENCY);
   localparam int IDX_W         = MEM_WORDS_LOG2 + 1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'((LATENCY < 2) ? 0 : LATENCY - 2);
   localparam logic [IDX_W-1:0]  MEM_DEPTH = IDX_W'(1) << MEM_WORDS_LOG2;

   ram_state_e                state_q, state_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic [CNT_W-1:0]          wait_q, wait_d;
   logic [MEM_WORDS_LOG2-1:0] base_word_q, base_word_d;
   logic                      err_q, err_d;

   logic [63:0]               base_addr;
   logic [MEM_WORDS_LOG2-1:0] req_base_word;
   logic [IDX_W-1:0]          req_line_end;
   logic                      req_upper_set;
   logic                      req_err;
   logic                      unused_byte_bits;

   logic [MEM_WORDS_LOG2-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0]     mem_rd_data;

   // Split the request address into the line's first word index and any bits
   // that point beyond storage. The end-of-line index is one bit wider than
   // the storage index so a line running off the top cannot wrap to zero.
   always_comb begin
      base_addr        = line_base(64'(req_addr), LINE_OFF_BITS);
      req_base_word    = base_addr[MEM_WORDS_LOG2+BYTE_OFF_BITS-1:BYTE_OFF_BITS];
      req_upper_set    = |base_addr[63:MEM_WORDS_LOG2+BYTE_OFF_BITS];
      req_line_end     = {1'b0, req_base_word} + IDX_W'(LINE_WORDS);
      req_err          = req_upper_set || (req_line_end > MEM_DEPTH);
      unused_byte_bits = ^base_addr[BYTE_OFF_BITS-1:0];
   end

   // Storage is indexed directly by the current beat; an error request never
   // reaches here with a live index because its data is forced to zero.
   assign mem_rd_addr = base_word_q + MEM_WORDS_LOG2'(beat_q);

   gelato_ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (MEM_WORDS_LOG2)
   ) u_ram_array (
      .clk     (clk),
      .wr_en   (load_en && rdy),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .rd_addr (mem_rd_addr),
      .rd_data (mem_rd_data)
   );

   // Handshake outputs. A preload in IDLE takes the cycle, so the request
   // is held off until the next one.
   always_comb begin
      req_ready  = (state_q == IDLE) && rdy && !load_en && !rst;
      resp_valid = (state_q == BURST);
      resp_error = resp_valid && err_q;
      resp_last  = resp_valid && (err_q || (beat_q == LAST_BEAT));
      resp_data  = (resp_valid && !err_q) ? mem_rd_data : '0;
   end

   // Next-state logic. Everything holds unless rdy is high, which is what
   // keeps the outputs stable through a global stall.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      wait_d      = wait_q;
      base_word_d = base_word_q;
      err_d       = err_q;
      if (rdy) begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready) begin
                  base_word_d = req_base_word;
                  err_d       = req_err;
                  beat_d      = '0;
                  if (LATENCY == 1) begin
                     state_d = BURST;
                  end else begin
                     state_d = WAIT;
                     wait_d  = WAIT_INIT;
                  end
               end
            end
            WAIT: begin
               // The counter was loaded with LATENCY-2 so the first beat
               // appears exactly LATENCY cycles after the request cycle.
               if (wait_q == '0) begin
                  state_d = BURST;
               end else begin
                  wait_d = wait_q - CNT_W'(1);
               end
            end
            BURST: begin
               if (resp_ready) begin
                  if (err_q || (beat_q == LAST_BEAT)) begin
                     state_d = IDLE;
                     beat_d  = '0;
                  end else begin
                     beat_d = beat_q + BEAT_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               beat_d  = '0;
            end
         endcase
      end
   end

   // State registers with synchronous reset; reset abandons any burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         wait_q      <= '0;
         base_word_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         wait_q      <= wait_d;
         base_word_q <= base_word_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_gelato_inst_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_gelato_inst_ram_responder
// Self-checking bench: a monitor pushes the expected beats of each accepted
// request into a scoreboard queue (from a shadow copy of storage) and checks
// every presented beat against the queue head, popping on handshake.
// ---------------------------------------------------------------------------
module tb_gelato_inst_ram_responder;
   import gelato_ram_pkg::*;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int LINE_WORDS = 8;
   localparam int MEM_LOG2   = 14;
   localparam int LAT        = 4;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
      logic                  err;
   } beat_t;

   logic                  clk;
   logic                  rst;
   logic                  rdy;
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  resp_last;
   logic                  resp_error;
   logic                  load_en;
   logic [MEM_LOG2-1:0]   load_addr;
   logic [DATA_WIDTH-1:0] load_data;

   int checkCount = 0;
   int errorCount = 0;
   int cyc        = 0;
   int acceptCyc  = 0;
   int expLat     = LAT;
   bit firstPending = 0;
   bit prevPending  = 0;

   beat_t                 sb[$];
   logic [DATA_WIDTH-1:0] modelMem [2**MEM_LOG2];

   gelato_inst_ram_responder #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .LINE_WORDS     (LINE_WORDS),
      .MEM_WORDS_LOG2 (MEM_LOG2),
      .LATENCY        (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_last  (resp_last),
      .resp_error (resp_error),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected beats for a request at byte address addr, from the shadow memory
   function automatic void pushExpected(input logic [ADDR_WIDTH-1:0] addr);
      logic [31:0] baseWord;
      beat_t       b;
      baseWord = (addr >> 2) & ~32'(LINE_WORDS - 1);
      if (((addr >> (MEM_LOG2 + 2)) != 0) || (baseWord + LINE_WORDS > (32'd1 << MEM_LOG2))) begin
         b.data = '0;
         b.last = 1'b1;
         b.err  = 1'b1;
         sb.push_back(b);
      end else begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            b.data = modelMem[baseWord + 32'(i)];
            b.last = (i == LINE_WORDS - 1);
            b.err  = 1'b0;
            sb.push_back(b);
         end
      end
   endfunction

   // Monitor: tracks preloads, accepted requests, latency and every beat
   always @(negedge clk) begin
      beat_t expBeat;
      cyc++;
      if (rst) begin
         sb.delete();
         firstPending = 0;
         prevPending  = 0;
      end else begin
         if (rdy && load_en) modelMem[load_addr] = load_data;
         if (prevPending) checkOutput("validHeld", 64'(resp_valid), 64'd1);
         if (resp_valid) begin
            if (firstPending) begin
               checkOutput("latency", 64'(cyc - acceptCyc), 64'(expLat));
               firstPending = 0;
            end
            if (sb.size() == 0) begin
               checkOutput("extraBeat", 64'(resp_valid), 64'd0);
            end else begin
               expBeat = sb[0];
               checkOutput("beatData", 64'(resp_data), 64'(expBeat.data));
               checkOutput("beatLast", 64'(resp_last), 64'(expBeat.last));
               checkOutput("beatError", 64'(resp_error), 64'(expBeat.err));
               if (resp_ready && rdy) void'(sb.pop_front());
            end
         end
         prevPending = resp_valid && !(resp_ready && rdy);
         if (rdy && req_valid && req_ready) begin
            acceptCyc    = cyc;
            firstPending = 1;
            pushExpected(req_addr);
         end
      end
   end

   // One preload write
   task automatic loadWord(input int idx, input logic [DATA_WIDTH-1:0] val);
      @(posedge clk); #1;
      load_en   = 1'b1;
      load_addr = MEM_LOG2'(idx);
      load_data = val;
   endtask

   task automatic loadIdle();
      @(posedge clk); #1;
      load_en = 1'b0;
   endtask

   // Present a request and hold it until accepted (bounded)
   task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] addr);
      int n;
      n = 0;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_addr  = addr;
      @(negedge clk);
      while (!(req_ready && rdy) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) checkOutput("reqAcceptTimeout", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Wait until the scoreboard drains and the responder is idle again
   task automatic waitDone();
      int n;
      n = 0;
      while ((sb.size() != 0 || !req_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) checkOutput("drainTimeout", 64'(sb.size()), 64'd0);
   endtask

   logic patBits [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      int n;
      rst        = 1'b1;
      rdy        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b1;
      load_en    = 1'b0;
      load_addr  = '0;
      load_data  = '0;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rstReqReady", 64'(req_ready), 64'd0);
      checkOutput("rstRespValid", 64'(resp_valid), 64'd0);
      checkOutput("rstRespData", 64'(resp_data), 64'd0);
      checkOutput("rstRespLast", 64'(resp_last), 64'd0);
      checkOutput("rstRespError", 64'(resp_error), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idleReqReady", 64'(req_ready), 64'd1);

      // Preload four lines
      for (int i = 0; i < 8; i++) loadWord(i, 32'h1000 + 32'(i));
      for (int i = 8; i < 16; i++) loadWord(i, 32'h2000 + 32'(i - 8));
      for (int i = 16; i < 24; i++) loadWord(i, 32'h3000 + 32'(i - 16));
      for (int i = 24; i < 32; i++) loadWord(i, 32'h4000 + 32'(i - 24));
      loadIdle();

      // Basic line read from inside line 0
      expLat = LAT;
      applyStimulus(32'h0000_000C);
      @(negedge clk);
      checkOutput("readyDropAfterAccept", 64'(req_ready), 64'd0);
      waitDone();

      // Backpressure on line 1
      applyStimulus(32'h0000_0020);
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         resp_ready = patBits[n % 4];
         n++;
      end
      resp_ready = 1'b1;
      waitDone();

      // Global stall in the middle of WAIT
      expLat = LAT + 3;
      applyStimulus(32'h0000_0044);
      rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1 rdy = 1'b1;
      waitDone();

      // Out-of-range request: one error beat, then idle
      expLat = LAT;
      applyStimulus(32'(1) << (MEM_LOG2 + 2));
      repeat (LAT) @(negedge clk);
      checkOutput("errBeatError", 64'(resp_error), 64'd1);
      checkOutput("errBeatLast", 64'(resp_last), 64'd1);
      @(negedge clk);
      checkOutput("readyAfterErr", 64'(req_ready), 64'd1);
      checkOutput("validAfterErr", 64'(resp_valid), 64'd0);
      waitDone();

      // Preload and request in the same idle cycle: load wins
      @(posedge clk); #1;
      load_en   = 1'b1;
      load_addr = MEM_LOG2'(24);
      load_data = 32'hABCD_0000;
      req_valid = 1'b1;
      req_addr  = 32'h0000_0060;
      @(negedge clk);
      checkOutput("collisionReady", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      load_en = 1'b0;
      @(negedge clk);
      checkOutput("collisionRetryReady", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      waitDone();

      // Reset in the middle of a burst, at beat 3
      applyStimulus(32'h0000_0000);
      n = 0;
      @(negedge clk);
      while (!(resp_valid && resp_data == 32'h1003) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) checkOutput("beat3Timeout", 64'(resp_data), 64'h1003);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("validAfterRst", 64'(resp_valid), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idleAfterRst", 64'(req_ready), 64'd1);
      applyStimulus(32'h0000_0000);
      waitDone();

      repeat (5) @(negedge clk);
      checkOutput("scoreboardEmpty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   // Hard stop if something hangs
   initial begin
      #500000;
      $display("[TB] FAIL globalTimeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
